// File: rtl/enc_pkg.sv
// Shared types and sizing for the registered priority encoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional error tracking is enabled by defining ONEHOT_CHECK_EN.
package enc_pkg;

    // Output buffer depth; the count-based state machine is built for exactly two entries.
    localparam int ENC_BUF_DEPTH = 2;

    // Width of the saturating multi-hot counter.
    localparam int ERR_CNT_W = 8;

    // Widest index a buffer entry can hold (covers N up to 256).
    localparam int ENC_IDX_W_MAX = 8;

    // Buffer occupancy; the encoding equals the number of stored results.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } enc_state_e;

    // One buffered result. The index is stored zero-extended and cut back to W at the output.
    typedef struct packed {
        logic [ENC_IDX_W_MAX-1:0] o;
        logic                     o_any;
`ifdef ONEHOT_CHECK_EN
        logic                     err;
`endif
    } enc_entry_t;

    // Saturating increment for the multi-hot counter.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (cnt == {ERR_CNT_W{1'b1}}) ? cnt : cnt + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/encoder_prio_comb.sv
// Combinational priority encoder: index of lowest set bit, any-set flag, optional multi-hot flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
module encoder_prio_comb #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] d,
    output logic [W-1:0] o,
    output logic         o_any
`ifdef ONEHOT_CHECK_EN
    ,
    output logic         multi
`endif
);

    // Scan from the top down so the lowest set bit is the last one written and wins.
    always_comb begin
        o     = '0;
        o_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (d[i]) begin
                o     = W'(i);
                o_any = 1'b1;
            end
        end
    end

`ifdef ONEHOT_CHECK_EN
    // Clearing the lowest set bit leaves something only if more than one bit was set.
    always_comb begin
        multi = |(d & (d - N'(1)));
    end
`endif

endmodule

// File: rtl/encoder_4x2_reg.sv
// Registered priority encoder with a 2-entry FIFO output buffer (define ONEHOT_CHECK_EN for err/err_cnt).
// Latency: result on out_valid the cycle after accept.
// Backpressure: in_ready is derived from registered occupancy only; drops low when both entries are held.
module encoder_4x2_reg
    import enc_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         d,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [W-1:0]         o,
    output logic                 o_any,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef ONEHOT_CHECK_EN
    ,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    enc_state_e state_q;
    enc_state_e state_nxt;
    logic       wptr_q;
    logic       rptr_q;
    enc_entry_t mem_q [ENC_BUF_DEPTH];
    enc_entry_t entry_new;
    enc_entry_t head;
    logic       accept;
    logic       deliver;
    logic [W-1:0] enc_o;
    logic         enc_any;
`ifdef ONEHOT_CHECK_EN
    logic                 enc_multi;
    logic [ERR_CNT_W-1:0] err_cnt_q;
`endif

    encoder_prio_comb #(.N(N)) u_prio (
        .d     (d),
        .o     (enc_o),
        .o_any (enc_any)
`ifdef ONEHOT_CHECK_EN
        ,
        .multi (enc_multi)
`endif
    );

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next occupancy: accept adds one, deliver removes one, both together leave it unchanged.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !deliver)      state_nxt = ST_TWO;
                else if (deliver && !accept) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (deliver) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake outputs depend only on registered state, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state_q != ST_TWO);
        out_valid = (state_q != ST_EMPTY);
        accept    = in_valid && in_ready;
        deliver   = out_valid && out_ready;
    end

    // Pack the encoder result into a buffer entry.
    always_comb begin
        entry_new       = '0;
        entry_new.o     = ENC_IDX_W_MAX'(enc_o);
        entry_new.o_any = enc_any;
`ifdef ONEHOT_CHECK_EN
        entry_new.err   = enc_multi;
`endif
    end

    // Buffer storage and 1-bit pointers; pointers toggle, which wraps 1 back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            for (int i = 0; i < ENC_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem_q[wptr_q] <= entry_new;
                wptr_q        <= ~wptr_q;
            end
            if (deliver) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

    // Head of the buffer drives the output; it only moves on deliver, so it is stable under stall.
    always_comb begin
        head  = mem_q[rptr_q];
        o     = W'(head.o);
        o_any = head.o_any;
    end

`ifdef ONEHOT_CHECK_EN
    // Count multi-hot requests at accept; saturates and only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (accept && enc_multi) begin
            err_cnt_q <= sat_inc(err_cnt_q);
        end
    end

    // The per-entry error flag is only meaningful alongside a valid result.
    always_comb begin
        err     = out_valid && head.err;
        err_cnt = err_cnt_q;
    end
`endif

endmodule

// File: tb/tb_encoder_4x2_reg.sv
// Self-checking bench for encoder_4x2_reg: queue model of the 2-entry buffer plus directed literals.
module tb_encoder_4x2_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] o;
    logic       o_any;
    logic       out_valid;
    logic       out_ready;
`ifdef ONEHOT_CHECK_EN
    logic       err;
    logic [7:0] err_cnt;
`endif

    encoder_4x2_reg #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .o         (o),
        .o_any     (o_any),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ONEHOT_CHECK_EN
        ,
        .err       (err),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int o;
        int any;
        int err;
    } exp_t;

    exp_t mq[$];
    int   m_errcnt = 0;
    int   n_chk    = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;
    int   got_o[$];
    int   got_any[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference encode: isolate the lowest set bit arithmetically, its log2 is the index.
    function automatic exp_t model_enc(input logic [3:0] v);
        exp_t e;
        logic [3:0] low;
        low   = v & (~v + 4'd1);
        e.o   = (v == 4'd0) ? 0 : $clog2(low);
        e.any = (v != 4'd0) ? 1 : 0;
        e.err = ($countones(v) > 1) ? 1 : 0;
        return e;
    endfunction

    // Model: a queue of at most two results, updated from the inputs at each rising edge.
    always @(posedge clk) begin
        bit acc;
        bit del;
        exp_t e;
        if (rst) begin
            mq.delete();
            m_errcnt = 0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            del = out_ready && (mq.size() > 0);
            if (del) void'(mq.pop_front());
            if (acc) begin
                e = model_enc(d);
                mq.push_back(e);
                if (e.err != 0 && m_errcnt < 255) m_errcnt++;
            end
        end
    end

    // Record what the DUT actually delivered, for the order checks.
    always @(posedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready) begin
            got_o.push_back(int'(o));
            got_any.push_back(int'(o_any));
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, (mq.size() < 2) ? 1 : 0);
            chk("out_valid", out_valid, (mq.size() != 0) ? 1 : 0);
            if (mq.size() != 0) begin
                chk("o", o, mq[0].o);
                chk("o_any", o_any, mq[0].any);
            end
`ifdef ONEHOT_CHECK_EN
            chk("err", err, (mq.size() != 0) ? mq[0].err : 0);
            chk("err_cnt", err_cnt, m_errcnt);
`endif
        end
    end

    // Present v until it is accepted; returns on the falling edge after the accepting edge.
    task automatic push(input logic [3:0] v);
        int   budget;
        logic rdy;
        budget   = 50;
        d        = v;
        in_valid = 1'b1;
        do begin
            rdy = in_ready;
            @(negedge clk);
            budget--;
        end while (rdy !== 1'b1 && budget > 0);
        if (rdy !== 1'b1) chk("push_accept", rdy, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_got(input string name, input int idx, input int exp_o, input int exp_any);
        if (idx < got_o.size()) begin
            chk({name, "_o"}, got_o[idx], exp_o);
            chk({name, "_any"}, got_any[idx], exp_any);
        end else begin
            chk({name, "_missing"}, got_o.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] multi_pat [5];
        multi_pat[0] = 4'b0011;
        multi_pat[1] = 4'b0110;
        multi_pat[2] = 4'b1100;
        multi_pat[3] = 4'b1111;
        multi_pat[4] = 4'b0101;

        rst       = 1'b1;
        d         = 4'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // 1: reset held two cycles
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_o", o, 0);
        chk("rst_o_any", o_any, 0);
`ifdef ONEHOT_CHECK_EN
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
`endif
        rst = 1'b0;

        // 2: one-hot stream, one result per cycle
        out_ready = 1'b1;
        got_o.delete(); got_any.delete();
        push(4'b0001);
        chk("lat_valid", out_valid, 1);
        chk("lat_o", o, 0);
        push(4'b0010);
        push(4'b0100);
        push(4'b1000);
        in_valid = 1'b0;
        idle(3);
        chk("t2_count", got_o.size(), 4);
        chk_got("t2_0", 0, 0, 1);
        chk_got("t2_1", 1, 1, 1);
        chk_got("t2_2", 2, 2, 1);
        chk_got("t2_3", 3, 3, 1);

        // 3: all-zero and multi-hot requests
        push(4'b0000);
        chk("zero_o", o, 0);
        chk("zero_any", o_any, 0);
        chk("zero_valid", out_valid, 1);
        push(4'b0110);
        chk("multi_o", o, 1);
        chk("multi_any", o_any, 1);
`ifdef ONEHOT_CHECK_EN
        chk("multi_err", err, 1);
        chk("multi_err_cnt", err_cnt, 1);
`endif
        in_valid = 1'b0;
        idle(3);

        // 4: stall fills the buffer, third request held until space frees
        out_ready = 1'b0;
        got_o.delete(); got_any.delete();
        push(4'b0010);
        push(4'b1000);
        chk("full_in_ready", in_ready, 0);
        d = 4'b0001;
        idle(2);
        chk("stall_valid", out_valid, 1);
        chk("stall_o", o, 1);
        chk("stall_in_ready", in_ready, 0);
        out_ready = 1'b1;
        push(4'b0001);
        in_valid = 1'b0;
        idle(4);
        chk("t4_count", got_o.size(), 3);
        chk_got("t4_0", 0, 1, 1);
        chk_got("t4_1", 1, 3, 1);
        chk_got("t4_2", 2, 0, 1);

        // 5: simultaneous accept and deliver with one entry held
        out_ready = 1'b0;
        got_o.delete(); got_any.delete();
        push(4'b1000);
        out_ready = 1'b1;
        push(4'b0100);
        chk("pass_in_ready", in_ready, 1);
        push(4'b0010);
        push(4'b0001);
        chk("pass_valid", out_valid, 1);
        in_valid = 1'b0;
        idle(3);
        chk("t5_count", got_o.size(), 4);
        chk_got("t5_0", 0, 3, 1);
        chk_got("t5_1", 1, 2, 1);
        chk_got("t5_2", 2, 1, 1);
        chk_got("t5_3", 3, 0, 1);

        // 6: reset while full, then saturate the multi-hot counter
        out_ready = 1'b0;
        push(4'b0011);
        push(4'b0101);
        in_valid = 1'b0;
        chk("pre_rst_full", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
`ifdef ONEHOT_CHECK_EN
        chk("mid_rst_err_cnt", err_cnt, 0);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push(multi_pat[i % 5]);
        end
        in_valid = 1'b0;
        idle(3);
        chk("sat_drained", out_valid, 0);
`ifdef ONEHOT_CHECK_EN
        chk("sat_err_cnt", err_cnt, 255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
